// File: rtl/uart_pkg.sv
// Shared constants and state types for the memory-mapped 8N1 UART.
package uart_pkg;

   localparam logic UART_DATA = 1'b0;
   localparam logic UART_STAT = 1'b1;

   localparam int unsigned ST_TX_FULL    = 0;
   localparam int unsigned ST_TX_EMPTY   = 1;
   localparam int unsigned ST_RX_VALID   = 2;
   localparam int unsigned ST_RX_OVR     = 3;
   localparam int unsigned ST_RX_FERR    = 4;
   localparam int unsigned ST_IRQ_EN_RX  = 5;
   localparam int unsigned ST_IRQ_EN_TXE = 6;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; full is judged before a same-cycle pop, so a push into a full FIFO is dropped.
module uart_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rptr_q];

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_ctrl.sv
// 6502-bus UART: DATA/STATUS registers, FIFO-fed 8N1 transmitter, single-byte 8N1 receiver, level IRQ.
module uart_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned BAUD     = 115200,
   parameter int unsigned TX_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       stb,
   input  logic       addr,
   input  logic       rwb,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   input  logic       rx_i,
   output logic       tx_o,
   output logic       irq_o
);
   localparam logic [15:0] DIV  = 16'((CLK_HZ + BAUD / 2) / BAUD);
   localparam logic [15:0] HALF = DIV >> 1;

   logic acc, wr_data, wr_stat, rd_data, rd_stat;
   assign acc     = cs & stb;
   assign wr_data = acc & ~rwb & (addr == UART_DATA);
   assign wr_stat = acc & ~rwb & (addr == UART_STAT);
   assign rd_data = acc &  rwb & (addr == UART_DATA);
   assign rd_stat = acc &  rwb & (addr == UART_STAT);

   logic       tx_pop, tx_full, fifo_empty, tx_empty;
   logic [7:0] fifo_rdata;

   uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (wr_data),
      .pop_i   (tx_pop),
      .wdata_i (data_in),
      .rdata_o (fifo_rdata),
      .full_o  (tx_full),
      .empty_o (fifo_empty)
   );

   tx_state_t   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic        tx_q, tx_line_d;

   assign tx_empty = fifo_empty & (tx_state_q == TX_IDLE);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TX_IDLE: if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = fifo_rdata;
            tx_cnt_d   = DIV - 16'd1;
            tx_state_d = TX_START;
         end
         TX_START: if (tx_cnt_q == '0) begin
            tx_cnt_d   = DIV - 16'd1;
            tx_bit_d   = '0;
            tx_state_d = TX_DATA;
         end else tx_cnt_d = tx_cnt_q - 16'd1;
         TX_DATA: if (tx_cnt_q == '0) begin
            tx_cnt_d = DIV - 16'd1;
            tx_sh_d  = tx_sh_q >> 1;
            if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            else                  tx_bit_d   = tx_bit_q + 3'd1;
         end else tx_cnt_d = tx_cnt_q - 16'd1;
         default: if (tx_cnt_q == '0) begin
            // Chain straight into the next start bit when more data is queued.
            if (!fifo_empty) begin
               tx_pop     = 1'b1;
               tx_sh_d    = fifo_rdata;
               tx_cnt_d   = DIV - 16'd1;
               tx_state_d = TX_START;
            end else tx_state_d = TX_IDLE;
         end else tx_cnt_d = tx_cnt_q - 16'd1;
      endcase
   end

   // Line is registered from the current state, so it lags the FSM by one cycle.
   always_comb begin
      case (tx_state_q)
         TX_START: tx_line_d = 1'b0;
         TX_DATA:  tx_line_d = tx_sh_q[0];
         default:  tx_line_d = 1'b1;
      endcase
   end

   logic        rx_s1_q, rx_s2_q;
   rx_state_t   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic        rx_done;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_done    = 1'b0;
      case (rx_state_q)
         RX_IDLE: if (!rx_s2_q) begin
            rx_cnt_d   = HALF - 16'd1;
            rx_state_d = RX_START;
         end
         RX_START: if (rx_cnt_q == '0) begin
            rx_cnt_d   = DIV - 16'd1;
            rx_bit_d   = '0;
            rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
         end else rx_cnt_d = rx_cnt_q - 16'd1;
         RX_DATA: if (rx_cnt_q == '0) begin
            rx_cnt_d = DIV - 16'd1;
            rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
         end else rx_cnt_d = rx_cnt_q - 16'd1;
         default: if (rx_cnt_q == '0) begin
            rx_done    = 1'b1;
            rx_state_d = RX_IDLE;
         end else rx_cnt_d = rx_cnt_q - 16'd1;
      endcase
   end

   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;
   logic       en_rx_q, en_rx_d, en_txe_q, en_txe_d, irq_q, irq_d;

   // New events win over same-edge read clears.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rd_data ? 1'b0 : rx_valid_q;
      rx_ovr_d   = rd_stat ? 1'b0 : rx_ovr_q;
      rx_ferr_d  = rd_stat ? 1'b0 : rx_ferr_q;
      if (rx_done) begin
         if (!rx_s2_q) rx_ferr_d = 1'b1;
         if (rx_valid_q && !rd_data) rx_ovr_d = 1'b1;
         else begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
         end
      end
      en_rx_d  = wr_stat ? data_in[ST_IRQ_EN_RX]  : en_rx_q;
      en_txe_d = wr_stat ? data_in[ST_IRQ_EN_TXE] : en_txe_q;
      irq_d    = (en_rx_q & rx_valid_q) | (en_txe_q & tx_empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_q       <= 1'b1;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         rx_ferr_q  <= 1'b0;
         en_rx_q    <= 1'b0;
         en_txe_q   <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_q       <= tx_line_d;
         rx_s1_q    <= rx_i;
         rx_s2_q    <= rx_s1_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_ovr_q   <= rx_ovr_d;
         rx_ferr_q  <= rx_ferr_d;
         en_rx_q    <= en_rx_d;
         en_txe_q   <= en_txe_d;
         irq_q      <= irq_d;
      end
   end

   logic [7:0] status;
   assign status = {1'b0, en_txe_q, en_rx_q, rx_ferr_q, rx_ovr_q, rx_valid_q, tx_empty, tx_full};

   assign data_out = !cs ? 8'h00 : (addr == UART_STAT) ? status : rx_data_q;
   assign tx_o     = tx_q;
   assign irq_o    = irq_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl with DIV = 16 (CLK_HZ = 160, BAUD = 10).
module tb_uart_ctrl;
   logic       clk = 1'b0;
   logic       rst, cs, stb, addr, rwb, rx_i;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       tx_o, irq_o;

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;

   uart_ctrl #(.CLK_HZ(160), .BAUD(10), .TX_DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .cs       (cs),
      .stb      (stb),
      .addr     (addr),
      .rwb      (rwb),
      .data_in  (data_in),
      .data_out (data_out),
      .rx_i     (rx_i),
      .tx_o     (tx_o),
      .irq_o    (irq_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_wr(input logic a, input logic [7:0] d, output int n);
      @(negedge clk);
      cs = 1'b1; stb = 1'b1; addr = a; rwb = 1'b0; data_in = d;
      @(posedge clk);
      #1;
      cs = 1'b0; stb = 1'b0; rwb = 1'b1;
      n = cyc;
   endtask

   task automatic bus_rd(input logic a, output logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; stb = 1'b1; addr = a; rwb = 1'b1;
      #1 d = data_out;
      @(posedge clk);
      #1;
      cs = 1'b0; stb = 1'b0;
   endtask

   task automatic peek(input logic a, output logic [7:0] d);
      cs = 1'b1; stb = 1'b0; addr = a; rwb = 1'b1;
      #1 d = data_out;
      cs = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] sym;
      sym = {stop, b, 1'b0};
      @(posedge clk);
      #1;
      for (int s = 0; s < 10; s++) begin
         rx_i = sym[s];
         repeat (16) @(posedge clk);
         #1;
      end
      rx_i = 1'b1;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [7:0] d;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      ntests++; if (tx_o !== 1'b1) begin nfail++; $display("FAIL reset_tx got=%b exp=1", tx_o); end
      ntests++; if (irq_o !== 1'b0) begin nfail++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
      ntests++; if (data_out !== 8'h00) begin nfail++; $display("FAIL reset_cs0_dout got=%h exp=00", data_out); end
      peek(1'b1, d);
      ntests++; if (d !== 8'h02) begin nfail++; $display("FAIL reset_status got=%h exp=02", d); end
      peek(1'b0, d);
      ntests++; if (d !== 8'h00) begin nfail++; $display("FAIL reset_rxdata got=%h exp=00", d); end
   endtask

   task automatic test_single_tx;
      int n;
      logic [7:0] d;
      logic [7:0] exp;
      exp = 8'hA5;
      bus_wr(1'b0, exp, n);
      ntests++; if (tx_o !== 1'b1) begin nfail++; $display("FAIL tx_n0 got=%b exp=1", tx_o); end
      wait_cyc(n + 1);
      ntests++; if (tx_o !== 1'b1) begin nfail++; $display("FAIL tx_n1 got=%b exp=1", tx_o); end
      wait_cyc(n + 2);
      ntests++; if (tx_o !== 1'b0) begin nfail++; $display("FAIL tx_start_edge got=%b exp=0", tx_o); end
      for (int j = 1; j <= 8; j++) begin
         wait_cyc(n + 2 + 16 * j + 8);
         ntests++; if (tx_o !== exp[j-1]) begin nfail++; $display("FAIL tx_bit%0d got=%b exp=%b", j - 1, tx_o, exp[j-1]); end
      end
      wait_cyc(n + 2 + 144 + 8);
      ntests++; if (tx_o !== 1'b1) begin nfail++; $display("FAIL tx_stop got=%b exp=1", tx_o); end
      wait_cyc(n + 159);
      peek(1'b1, d);
      ntests++; if (d[1] !== 1'b0) begin nfail++; $display("FAIL tx_empty_during got=%b exp=0", d[1]); end
      wait_cyc(n + 162);
      peek(1'b1, d);
      ntests++; if (d[1] !== 1'b1) begin nfail++; $display("FAIL tx_empty_after got=%b exp=1", d[1]); end
   endtask

   task automatic test_fifo_full;
      int n0, n;
      logic [7:0] d;
      logic [7:0] bytes [6];
      logic [9:0] sym;
      bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h80;
      bytes[3] = 8'hFF; bytes[4] = 8'h5A; bytes[5] = 8'h77;
      // Entry 0 is popped one cycle after its write, so entries 1..4 fill the FIFO.
      bus_wr(1'b0, bytes[0], n0);
      for (int i = 1; i < 5; i++) bus_wr(1'b0, bytes[i], n);
      peek(1'b1, d);
      ntests++; if (d[0] !== 1'b1) begin nfail++; $display("FAIL fifo_full_flag got=%b exp=1", d[0]); end
      bus_wr(1'b0, bytes[5], n);
      for (int k = 0; k < 5; k++) begin
         sym = {1'b1, bytes[k], 1'b0};
         for (int j = 0; j < 10; j++) begin
            wait_cyc(n0 + 2 + 160 * k + 16 * j + 8);
            ntests++;
            if (tx_o !== sym[j]) begin
               nfail++; $display("FAIL b2b_frame%0d_sym%0d got=%b exp=%b", k, j, tx_o, sym[j]);
            end
         end
      end
      wait_cyc(n0 + 2 + 800 + 8);
      ntests++; if (tx_o !== 1'b1) begin nfail++; $display("FAIL dropped_byte_sent got=%b exp=1", tx_o); end
      peek(1'b1, d);
      ntests++; if (d !== 8'h02) begin nfail++; $display("FAIL fifo_drained_status got=%h exp=02", d); end
   endtask

   task automatic test_rx;
      logic [7:0] d;
      send_rx(8'h3C, 1'b1);
      peek(1'b1, d);
      ntests++; if (d !== 8'h06) begin nfail++; $display("FAIL rx_status_valid got=%h exp=06", d); end
      bus_rd(1'b0, d);
      ntests++; if (d !== 8'h3C) begin nfail++; $display("FAIL rx_data got=%h exp=3c", d); end
      peek(1'b1, d);
      ntests++; if (d !== 8'h02) begin nfail++; $display("FAIL rx_valid_cleared got=%h exp=02", d); end
   endtask

   task automatic test_overrun;
      logic [7:0] d;
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      bus_rd(1'b0, d);
      ntests++; if (d !== 8'h11) begin nfail++; $display("FAIL ovr_data got=%h exp=11", d); end
      bus_rd(1'b1, d);
      ntests++; if (d !== 8'h0A) begin nfail++; $display("FAIL ovr_status got=%h exp=0a", d); end
      peek(1'b1, d);
      ntests++; if (d !== 8'h02) begin nfail++; $display("FAIL ovr_cleared got=%h exp=02", d); end
   endtask

   task automatic test_rx_faults;
      logic [7:0] d;
      @(posedge clk);
      #1 rx_i = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx_i = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      peek(1'b1, d);
      ntests++; if (d !== 8'h02) begin nfail++; $display("FAIL glitch_status got=%h exp=02", d); end
      send_rx(8'hC3, 1'b1);
      bus_rd(1'b0, d);
      ntests++; if (d !== 8'hC3) begin nfail++; $display("FAIL after_glitch_data got=%h exp=c3", d); end
      send_rx(8'h55, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      bus_rd(1'b1, d);
      ntests++; if (d !== 8'h16) begin nfail++; $display("FAIL ferr_status got=%h exp=16", d); end
      bus_rd(1'b0, d);
      ntests++; if (d !== 8'h55) begin nfail++; $display("FAIL ferr_data got=%h exp=55", d); end
      peek(1'b1, d);
      ntests++; if (d !== 8'h02) begin nfail++; $display("FAIL ferr_cleared got=%h exp=02", d); end
   endtask

   task automatic test_irq_reset;
      int n;
      logic [7:0] d;
      bus_wr(1'b1, 8'h60, n);
      ntests++; if (irq_o !== 1'b0) begin nfail++; $display("FAIL irq_same_edge got=%b exp=0", irq_o); end
      wait_cyc(n + 1);
      ntests++; if (irq_o !== 1'b1) begin nfail++; $display("FAIL irq_txe got=%b exp=1", irq_o); end
      bus_wr(1'b1, 8'h00, n);
      wait_cyc(n + 1);
      ntests++; if (irq_o !== 1'b0) begin nfail++; $display("FAIL irq_disabled got=%b exp=0", irq_o); end
      send_rx(8'h9A, 1'b1);
      bus_wr(1'b1, 8'h20, n);
      wait_cyc(n + 1);
      ntests++; if (irq_o !== 1'b1) begin nfail++; $display("FAIL irq_rx got=%b exp=1", irq_o); end
      bus_wr(1'b0, 8'h00, n);
      wait_cyc(n + 30);
      ntests++; if (tx_o !== 1'b0) begin nfail++; $display("FAIL midframe_tx got=%b exp=0", tx_o); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      ntests++; if (tx_o !== 1'b1) begin nfail++; $display("FAIL rst_tx got=%b exp=1", tx_o); end
      ntests++; if (irq_o !== 1'b0) begin nfail++; $display("FAIL rst_irq got=%b exp=0", irq_o); end
      rst = 1'b0;
      peek(1'b1, d);
      ntests++; if (d !== 8'h02) begin nfail++; $display("FAIL rst_status got=%h exp=02", d); end
      peek(1'b0, d);
      ntests++; if (d !== 8'h00) begin nfail++; $display("FAIL rst_rxdata got=%h exp=00", d); end
   endtask

   initial begin
      rst = 1'b1; cs = 1'b0; stb = 1'b0; addr = 1'b0; rwb = 1'b1;
      data_in = 8'h00; rx_i = 1'b1;
      test_reset;
      test_single_tx;
      test_fifo_full;
      test_rx;
      test_overrun;
      test_rx_faults;
      test_irq_reset;
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
